dnn_result_unit: RTL and testbench

Parametrised result stage that sits behind the inference core's class-score outputs. It captures all class scores into a register bank when the core signals completion. It then finds the predicted class with a sequential signed argmax scan, and serves registered, indexed read-back of any score. This replaces the fixed 10-way combinational output mux and adds prediction, validity flags and a soft clear.

---
 rtl/dnn_pkg.sv | 21 ++
 rtl/dnn_argmax_scan.sv | 52 +++++
 rtl/dnn_result_unit.sv | 136 +++++++++++++
 tb/tb_dnn_result_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and defaults for the DNN result stage: score type, FSM encoding
// and the index-width helper used to size class indices.
package dnn_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_NUM_CLASSES = 10;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } res_state_t;

  // A single class still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dnn_argmax_scan.sv
// Sequential signed argmax: i_start seeds the running best with class 0, then each
// i_step folds in one more score; o_done flags the step that handles the last class.
module dnn_argmax_scan
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int IDX_WIDTH   = idx_width(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         i_flush,
  input  logic                         i_start,
  input  logic signed [DATA_WIDTH-1:0] i_first,
  input  logic                         i_step,
  input  logic signed [DATA_WIDTH-1:0] i_score,
  output logic [IDX_WIDTH-1:0]         o_scan_idx,
  output logic                         o_done,
  output logic signed [DATA_WIDTH-1:0] o_best_next,
  output logic [IDX_WIDTH-1:0]         o_best_idx_next
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  logic signed [DATA_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]         r_best_idx;
  logic [IDX_WIDTH-1:0]         r_scan_idx;
  logic                         w_take;

  // Strict compare keeps the lowest index on ties.
  assign w_take          = i_score > r_best;
  assign o_best_next     = w_take ? i_score : r_best;
  assign o_best_idx_next = w_take ? r_scan_idx : r_best_idx;
  assign o_done          = i_step && (r_scan_idx == LAST_IDX);
  assign o_scan_idx      = r_scan_idx;

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_best     <= '0;
      r_best_idx <= '0;
      r_scan_idx <= '0;
    end else if (i_start) begin
      r_best     <= i_first;
      r_best_idx <= '0;
      r_scan_idx <= IDX_WIDTH'(1);
    end else if (i_step) begin
      r_best     <= o_best_next;
      r_best_idx <= o_best_idx_next;
      r_scan_idx <= r_scan_idx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dnn_result_unit.sv
// Result stage behind the inference core: captures all class scores on the rising
// edge of core_done, scans for the argmax and serves registered indexed read-back.
module dnn_result_unit
  import dnn_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int  NUM_CLASSES = DEFAULT_NUM_CLASSES,
  localparam int IDX_WIDTH   = idx_width(NUM_CLASSES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  core_done,
  input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] core_out,
  input  logic                                  clear,
  input  logic [IDX_WIDTH-1:0]                  out_idx,
  output logic signed [DATA_WIDTH-1:0]          out,
  output logic                                  out_valid,
  output logic [IDX_WIDTH-1:0]                  pred_idx,
  output logic signed [DATA_WIDTH-1:0]          pred_score,
  output logic                                  pred_valid,
  output logic                                  busy,
  output res_state_t                            dbg_state
);

  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] r_bank;
  res_state_t                   r_state;
  logic                         r_done_q;
  logic signed [DATA_WIDTH-1:0] r_out;
  logic                         r_out_valid;
  logic [IDX_WIDTH-1:0]         r_pred_idx;
  logic signed [DATA_WIDTH-1:0] r_pred_score;
  logic                         r_pred_valid;
  logic                         r_busy;

  logic                         w_capture;
  logic                         w_flush;
  logic                         w_start;
  logic                         w_step;
  logic                         w_scan_done;
  logic [IDX_WIDTH-1:0]         w_scan_idx;
  logic [IDX_WIDTH-1:0]         w_best_idx_next;
  logic signed [DATA_WIDTH-1:0] w_best_next;
  logic signed [DATA_WIDTH-1:0] w_rd_score;
  logic signed [DATA_WIDTH-1:0] w_scan_score;

  assign w_capture = core_done & ~r_done_q;
  assign w_flush   = rst | clear;
  assign w_start   = w_capture && (r_state != SCAN);
  assign w_step    = (r_state == SCAN);

  // Edge detector keeps tracking core_done through a soft clear.
  always_ff @(posedge clk) begin
    if (rst) r_done_q <= 1'b0;
    else     r_done_q <= core_done;
  end

  // Out-of-range read indices fall back to class 0.
  always_comb begin
    w_rd_score   = r_bank[0];
    w_scan_score = r_bank[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (out_idx == IDX_WIDTH'(i))    w_rd_score   = r_bank[i];
      if (w_scan_idx == IDX_WIDTH'(i)) w_scan_score = r_bank[i];
    end
  end

  dnn_argmax_scan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CLASSES (NUM_CLASSES),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_scan (
    .clk             (clk),
    .i_flush         (w_flush),
    .i_start         (w_start),
    .i_first         ($signed(core_out[0])),
    .i_step          (w_step),
    .i_score         (w_scan_score),
    .o_scan_idx      (w_scan_idx),
    .o_done          (w_scan_done),
    .o_best_next     (w_best_next),
    .o_best_idx_next (w_best_idx_next)
  );

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state      <= IDLE;
      r_bank       <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_pred_idx   <= '0;
      r_pred_score <= '0;
      r_pred_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out <= w_rd_score;
      case (r_state)
        IDLE, DONE: begin
          if (w_capture) begin
            r_bank      <= core_out;
            r_out_valid <= 1'b1;
            if (NUM_CLASSES == 1) begin
              r_state      <= DONE;
              r_pred_valid <= 1'b1;
              r_pred_idx   <= '0;
              r_pred_score <= $signed(core_out[0]);
            end else begin
              r_state      <= SCAN;
              r_busy       <= 1'b1;
              r_pred_valid <= 1'b0;
            end
          end
        end
        SCAN: begin
          // Final step's compare result is taken straight from the scanner.
          if (w_scan_done) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_pred_valid <= 1'b1;
            r_pred_idx   <= w_best_idx_next;
            r_pred_score <= w_best_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign pred_idx   = r_pred_idx;
  assign pred_score = r_pred_score;
  assign pred_valid = r_pred_valid;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_dnn_result_unit.sv
// Bench for dnn_result_unit: default 10x8 instance plus 4x16 and 1x8 instances,
// table vectors, randomized scores against an argmax reference, and corner sequences.
module tb_dnn_result_unit;
  import dnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clear;

  // Default instance: 10 classes x 8 bits
  logic                    a_core_done;
  logic [9:0][7:0]         a_core_out;
  logic [3:0]              a_out_idx;
  logic signed [7:0]       a_out;
  logic                    a_out_valid;
  logic [3:0]              a_pred_idx;
  logic signed [7:0]       a_pred_score;
  logic                    a_pred_valid;
  logic                    a_busy;
  res_state_t              a_dbg;

  // 4 classes x 16 bits
  logic                    b_core_done;
  logic [3:0][15:0]        b_core_out;
  logic [1:0]              b_out_idx;
  logic signed [15:0]      b_out;
  logic                    b_out_valid;
  logic [1:0]              b_pred_idx;
  logic signed [15:0]      b_pred_score;
  logic                    b_pred_valid;
  logic                    b_busy;
  res_state_t              b_dbg;

  // 1 class x 8 bits
  logic                    c_core_done;
  logic [0:0][7:0]         c_core_out;
  logic [0:0]              c_out_idx;
  logic signed [7:0]       c_out;
  logic                    c_out_valid;
  logic [0:0]              c_pred_idx;
  logic signed [7:0]       c_pred_score;
  logic                    c_pred_valid;
  logic                    c_busy;
  res_state_t              c_dbg;

  dnn_result_unit #(.DATA_WIDTH(8), .NUM_CLASSES(10)) u_a (
    .clk(clk), .rst(rst), .core_done(a_core_done), .core_out(a_core_out), .clear(clear),
    .out_idx(a_out_idx), .out(a_out), .out_valid(a_out_valid), .pred_idx(a_pred_idx),
    .pred_score(a_pred_score), .pred_valid(a_pred_valid), .busy(a_busy), .dbg_state(a_dbg)
  );

  dnn_result_unit #(.DATA_WIDTH(16), .NUM_CLASSES(4)) u_b (
    .clk(clk), .rst(rst), .core_done(b_core_done), .core_out(b_core_out), .clear(clear),
    .out_idx(b_out_idx), .out(b_out), .out_valid(b_out_valid), .pred_idx(b_pred_idx),
    .pred_score(b_pred_score), .pred_valid(b_pred_valid), .busy(b_busy), .dbg_state(b_dbg)
  );

  dnn_result_unit #(.DATA_WIDTH(8), .NUM_CLASSES(1)) u_c (
    .clk(clk), .rst(rst), .core_done(c_core_done), .core_out(c_core_out), .clear(clear),
    .out_idx(c_out_idx), .out(c_out), .out_valid(c_out_valid), .pred_idx(c_pred_idx),
    .pred_score(c_pred_score), .pred_valid(c_pred_valid), .busy(c_busy), .dbg_state(c_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int s[10];
    int exp_idx;
    int exp_score;
  } vec_t;

  localparam int NV = 6;
  vec_t vt[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: first occurrence of the maximum value among the first n scores.
  function automatic void ref_argmax(input int s[16], input int n, output int idx,
                                     output int best);
    idx  = 0;
    best = s[0];
    for (int i = 1; i < n; i++) begin
      if (s[i] > best) begin
        best = s[i];
        idx  = i;
      end
    end
  endfunction

  task automatic load_a(input int s[10]);
    for (int i = 0; i < 10; i++) a_core_out[i] = 8'(s[i]);
  endtask

  // One-cycle core_done pulse on instance A; returns cycles to pred_valid and busy count.
  task automatic pulse_a(input string tag, output int lat, output int bcnt);
    a_core_done = 1'b1;
    tick();
    a_core_done = 1'b0;
    check({tag, "_busy_t1"}, a_busy, 1);
    check({tag, "_out_valid_t1"}, a_out_valid, 1);
    check({tag, "_pred_valid_t1"}, a_pred_valid, 0);
    lat  = 1;
    bcnt = 0;
    while (!a_pred_valid && lat < 50) begin
      if (a_busy) bcnt++;
      tick();
      lat++;
    end
    check({tag, "_busy_done"}, a_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, ridx, rbest, ri, rises, pv_seen;
    int s16[16];
    int s10[10];
    logic prev_busy;

    vt[0] = '{'{3, -5, 7, 1, 0, -128, 7, 2, 6, 127}, 9, 127};
    vt[1] = '{'{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1}, 0, -1};
    vt[2] = '{'{5, 9, 9, 0, 0, 0, 0, 0, 0, 0}, 1, 9};
    vt[3] = '{'{-128, -128, -128, -128, -128, -128, -128, -127, -128, -128}, 7, -127};
    vt[4] = '{'{127, 127, 127, 127, 127, 127, 127, 127, 127, 127}, 0, 127};
    vt[5] = '{'{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}, 0, -128};

    rst = 1'b1; clear = 1'b0;
    a_core_done = 1'b0; a_core_out = '0; a_out_idx = '0;
    b_core_done = 1'b0; b_core_out = '0; b_out_idx = '0;
    c_core_done = 1'b0; c_core_out = '0; c_out_idx = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_out_valid", a_out_valid, 0);
    check("rst_pred_valid", a_pred_valid, 0);
    check("rst_pred_idx", a_pred_idx, 0);
    check("rst_pred_score", a_pred_score, 0);
    check("rst_busy", a_busy, 0);
    check("rst_out", a_out, 0);
    check("rst_b_pred_valid", b_pred_valid, 0);
    check("rst_c_pred_valid", c_pred_valid, 0);

    // Table vectors
    for (int k = 0; k < NV; k++) begin
      load_a(vt[k].s);
      pulse_a($sformatf("vec%0d", k), lat, bcnt);
      check($sformatf("vec%0d_latency", k), lat, 10);
      check($sformatf("vec%0d_busy_cycles", k), bcnt, 9);
      check($sformatf("vec%0d_pred_valid", k), a_pred_valid, 1);
      check($sformatf("vec%0d_pred_idx", k), a_pred_idx, vt[k].exp_idx);
      check($sformatf("vec%0d_pred_score", k), a_pred_score, vt[k].exp_score);
      if (k == 0) begin
        for (int idx = 0; idx < 16; idx++) begin
          a_out_idx = 4'(idx);
          tick();
          check($sformatf("readback_idx%0d", idx), a_out,
                (idx < 10) ? vt[0].s[idx] : vt[0].s[0]);
        end
      end
    end

    // Randomized scores, alternating full-range and tie-heavy narrow range
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) s16[i] = 0;
      for (int i = 0; i < 10; i++) begin
        s10[i] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128
                              : int'($urandom_range(0, 3)) - 2;
        s16[i] = s10[i];
      end
      ref_argmax(s16, 10, ridx, rbest);
      load_a(s10);
      pulse_a($sformatf("rnd%0d", r), lat, bcnt);
      check($sformatf("rnd%0d_latency", r), lat, 10);
      check($sformatf("rnd%0d_pred_idx", r), a_pred_idx, ridx);
      check($sformatf("rnd%0d_pred_score", r), a_pred_score, rbest);
      ri = int'($urandom_range(0, 15));
      a_out_idx = 4'(ri);
      tick();
      check($sformatf("rnd%0d_readback%0d", r, ri), a_out, (ri < 10) ? s10[ri] : s10[0]);
    end

    // core_done held high for 30 cycles with core_out changing mid-scan
    s10 = '{10, 20, -3, 50, 4, 4, 4, 4, 4, 4};
    load_a(s10);
    a_core_done = 1'b1;
    prev_busy = a_busy;
    rises = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (a_busy && !prev_busy) rises++;
      prev_busy = a_busy;
      if (c == 2) for (int i = 0; i < 10; i++) a_core_out[i] = 8'd100;
    end
    check("hold_capture_count", rises, 1);
    check("hold_pred_valid", a_pred_valid, 1);
    check("hold_pred_idx", a_pred_idx, 3);
    check("hold_pred_score", a_pred_score, 50);
    a_core_done = 1'b0;
    a_out_idx = 4'd0;
    tick();
    check("hold_bank0_original", a_out, 10);

    // clear coincident with the core_done edge
    a_core_done = 1'b1;
    clear = 1'b1;
    a_out_idx = 4'd3;
    tick();
    clear = 1'b0;
    check("clear_out_valid", a_out_valid, 0);
    check("clear_pred_valid", a_pred_valid, 0);
    check("clear_pred_idx", a_pred_idx, 0);
    check("clear_pred_score", a_pred_score, 0);
    check("clear_busy", a_busy, 0);
    check("clear_out", a_out, 0);
    repeat (3) tick();
    check("clear_edge_lost_out_valid", a_out_valid, 0);
    check("clear_edge_lost_busy", a_busy, 0);
    a_core_done = 1'b0;
    tick();

    // rst at SCAN cycle 4
    load_a(vt[0].s);
    a_core_done = 1'b1;
    tick();
    a_core_done = 1'b0;
    repeat (3) tick();
    check("rstscan_busy_before", a_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstscan_out_valid", a_out_valid, 0);
    check("rstscan_busy", a_busy, 0);
    check("rstscan_pred_valid", a_pred_valid, 0);
    check("rstscan_pred_idx", a_pred_idx, 0);
    check("rstscan_pred_score", a_pred_score, 0);
    check("rstscan_out", a_out, 0);
    pv_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (a_pred_valid) pv_seen++;
    end
    check("rstscan_pred_never", pv_seen, 0);

    // 4 classes x 16 bits
    b_core_out[0] = 16'(-300);
    b_core_out[1] = 16'(1000);
    b_core_out[2] = 16'(-32768);
    b_core_out[3] = 16'(999);
    b_core_done = 1'b1;
    tick();
    b_core_done = 1'b0;
    check("b_busy_t1", b_busy, 1);
    lat = 1; bcnt = 0;
    while (!b_pred_valid && lat < 50) begin
      if (b_busy) bcnt++;
      tick();
      lat++;
    end
    check("b_latency", lat, 4);
    check("b_busy_cycles", bcnt, 3);
    check("b_pred_idx", b_pred_idx, 1);
    check("b_pred_score", b_pred_score, 1000);
    b_out_idx = 2'd2;
    tick();
    check("b_readback2", b_out, -32768);

    // 1 class
    c_core_out[0] = 8'(-7);
    c_core_done = 1'b1;
    tick();
    c_core_done = 1'b0;
    check("c_pred_valid_t1", c_pred_valid, 1);
    check("c_busy_t1", c_busy, 0);
    check("c_pred_idx", c_pred_idx, 0);
    check("c_pred_score", c_pred_score, -7);
    c_out_idx = 1'b1;
    tick();
    check("c_readback_oob", c_out, -7);
    c_core_out[0] = 8'd100;
    c_core_done = 1'b1;
    tick();
    c_core_done = 1'b0;
    check("c_recapture_pred_valid", c_pred_valid, 1);
    check("c_recapture_busy", c_busy, 0);
    check("c_recapture_score", c_pred_score, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
